// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory between the CPU port (0) and the boot/debug port (1).
// Holds one registered transaction toward memory; a wait-state timeout aborts hung accesses.
//
// state | meaning
// IDLE  | no transaction; sample requests and grant
// BUSY  | mem_req asserted, waiting for mem_ready or timeout
// DONE  | one-cycle ack/err to the owner; requests ignored
module mem_port_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_ack,
  output logic              m0_err,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_ack,
  output logic              m1_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              owner,
  output logic              busy
);

  localparam int CNT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [CNT_W-1:0] WAIT_LAST = (MAX_WAIT > 0) ? CNT_W'(MAX_WAIT - 1) : '0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  wait_cnt_q;
  logic              last_grant_q;
  logic              owner_q;
  logic              busy_q;
  logic              mem_req_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              m0_ack_q, m1_ack_q;
  logic              m0_err_q, m1_err_q;
  logic [DATA_W-1:0] m0_rdata_q, m1_rdata_q;
  logic              grant_d;
  logic              timeout_d;

  // On contention the port that did not win last time gets the grant.
  assign grant_d   = (m0_req && m1_req) ? ~last_grant_q : m1_req;
  assign timeout_d = (MAX_WAIT != 0) && (wait_cnt_q == WAIT_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      wait_cnt_q   <= '0;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      busy_q       <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      m0_ack_q     <= 1'b0;
      m1_ack_q     <= 1'b0;
      m0_err_q     <= 1'b0;
      m1_err_q     <= 1'b0;
      m0_rdata_q   <= '0;
      m1_rdata_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (m0_req || m1_req) begin
            owner_q      <= grant_d;
            last_grant_q <= grant_d;
            mem_req_q    <= 1'b1;
            mem_we_q     <= grant_d ? m1_we    : m0_we;
            mem_addr_q   <= grant_d ? m1_addr  : m0_addr;
            mem_wdata_q  <= grant_d ? m1_wdata : m0_wdata;
            wait_cnt_q   <= '0;
            busy_q       <= 1'b1;
            state_q      <= BUSY;
          end
        end
        BUSY: begin
          // Ready takes priority over a coincident timeout.
          if (mem_ready || timeout_d) begin
            mem_req_q <= 1'b0;
            state_q   <= DONE;
            if (owner_q) m1_ack_q <= 1'b1;
            else         m0_ack_q <= 1'b1;
            if (mem_ready) begin
              if (!mem_we_q) begin
                if (owner_q) m1_rdata_q <= mem_rdata;
                else         m0_rdata_q <= mem_rdata;
              end
            end else begin
              if (owner_q) m1_err_q <= 1'b1;
              else         m0_err_q <= 1'b1;
            end
          end else if (MAX_WAIT != 0) begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
        end
        DONE: begin
          m0_ack_q <= 1'b0;
          m1_ack_q <= 1'b0;
          m0_err_q <= 1'b0;
          m1_err_q <= 1'b0;
          busy_q   <= 1'b0;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign owner     = owner_q;
  assign busy      = busy_q;
  assign m0_ack    = m0_ack_q;
  assign m1_ack    = m1_ack_q;
  assign m0_err    = m0_err_q;
  assign m1_err    = m1_err_q;
  assign m0_rdata  = m0_rdata_q;
  assign m1_rdata  = m1_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random traffic checked against
// a transaction-level model (round-robin grant, completion cycle from wait count).
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MW = 15;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
  logic [AW-1:0] m0_addr = '0, m1_addr = '0;
  logic [DW-1:0] m0_wdata = '0, m1_wdata = '0;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          m0_ack, m0_err, m1_ack, m1_err;
  logic          mem_req, mem_we, mem_ready = 1'b0;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata = '0;
  logic          owner, busy;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_rdata(m0_rdata), .m0_ack(m0_ack), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_rdata(m1_rdata), .m1_ack(m1_ack), .m1_err(m1_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .owner(owner), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: pending requests per port, last granted port, delivered read data.
  int            last_g;
  logic          pend [2];
  logic          p_we [2];
  logic [AW-1:0] p_addr [2];
  logic [DW-1:0] p_wdata [2];
  logic [DW-1:0] exp_rd [2];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic ack_of(input int p);
    return (p != 0) ? m1_ack : m0_ack;
  endfunction

  function automatic logic err_of(input int p);
    return (p != 0) ? m1_err : m0_err;
  endfunction

  function automatic logic [DW-1:0] rd_of(input int p);
    return (p != 0) ? m1_rdata : m0_rdata;
  endfunction

  task automatic drive_reqs();
    m0_req = pend[0]; m0_we = p_we[0]; m0_addr = p_addr[0]; m0_wdata = p_wdata[0];
    m1_req = pend[1]; m1_we = p_we[1]; m1_addr = p_addr[1]; m1_wdata = p_wdata[1];
  endtask

  task automatic new_req(input int p, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    pend[p] = 1'b1; p_we[p] = we; p_addr[p] = a; p_wdata[p] = d;
  endtask

  task automatic model_reset();
    last_g = 1;
    exp_rd[0] = '0;
    exp_rd[1] = '0;
  endtask

  // One full transaction starting with the DUT in IDLE; memory answers after w wait cycles.
  task automatic run_txn(input int w, input logic [DW-1:0] rd);
    int            g, dn;
    logic          to, gwe;
    logic [AW-1:0] ga;
    logic [DW-1:0] gd;
    drive_reqs();
    g = (pend[0] && pend[1]) ? 1 - last_g : (pend[1] ? 1 : 0);
    last_g = g;
    gwe = p_we[g]; ga = p_addr[g]; gd = p_wdata[g];
    to = (MW != 0) && (w >= MW);
    dn = to ? MW - 1 : w;
    step();
    chk("grant_owner", owner, g);
    chk("grant_we", mem_we, gwe);
    chk("grant_wdata", mem_wdata, gd);
    chk("grant_busy", busy, 1);
    for (int c = 0; c <= dn; c++) begin
      chk("busy_mem_req", mem_req, 1);
      chk("busy_addr", mem_addr, ga);
      chk("busy_no_ack", {m0_ack, m1_ack}, 0);
      if (g != 0) begin m1_addr = $urandom; m1_wdata = $urandom; m1_we = ~m1_we; end
      else        begin m0_addr = $urandom; m0_wdata = $urandom; m0_we = ~m0_we; end
      mem_ready = (c == w);
      mem_rdata = (c == w) ? rd : $urandom;
      step();
    end
    if (!to && !gwe) exp_rd[g] = rd;
    chk("done_ack", ack_of(g), 1);
    chk("done_err", err_of(g), to);
    chk("done_other_ack", {ack_of(1 - g), err_of(1 - g)}, 0);
    chk("done_rdata", rd_of(g), exp_rd[g]);
    chk("done_other_rdata", rd_of(1 - g), exp_rd[1 - g]);
    chk("done_mem_req", mem_req, 0);
    chk("done_busy", busy, 1);
    pend[g] = 1'b0;
    drive_reqs();
    mem_ready = 1'($urandom);
    step();
    mem_ready = 1'b0;
    chk("idle_ack", {m0_ack, m1_ack, m0_err, m1_err}, 0);
    chk("idle_busy", {busy, mem_req}, 0);
    chk("idle_rdata0", m0_rdata, exp_rd[0]);
    chk("idle_rdata1", m1_rdata, exp_rd[1]);
  endtask

  initial begin
    int g;
    pend[0] = 0; pend[1] = 0;
    p_we[0] = 0; p_we[1] = 0;
    p_addr[0] = '0; p_addr[1] = '0;
    p_wdata[0] = '0; p_wdata[1] = '0;
    model_reset();

    step();
    chk("rst_mem", {mem_req, mem_we, mem_addr, mem_wdata}, 0);
    chk("rst_port", {m0_ack, m1_ack, m0_err, m1_err, owner, busy}, 0);
    chk("rst_rdata", {m0_rdata, m1_rdata}, 0);
    reset = 1'b0;

    // Single read on port 0, ready in the first BUSY cycle.
    new_req(0, 1'b0, 32'h100, 32'h0);
    run_txn(0, 32'hDEADBEEF);
    // Write on port 1 with three wait states.
    new_req(1, 1'b1, 32'h20, 32'h12345678);
    run_txn(3, 32'hCAFEF00D);
    // Timeout, then a normal request, then ready on the last allowed cycle.
    new_req(0, 1'b0, 32'h44, 32'h0);
    run_txn(MW + 5, 32'h0BADBAD0);
    new_req(0, 1'b0, 32'h48, 32'h0);
    run_txn(2, 32'h11112222);
    new_req(0, 1'b0, 32'h4C, 32'h0);
    run_txn(MW - 1, 32'h33334444);

    // Random traffic, including contention and timeouts.
    for (int i = 0; i < 40; i++) begin
      for (int p = 0; p < 2; p++)
        if (!pend[p] && ($urandom_range(0, 2) != 0))
          new_req(p, 1'($urandom), $urandom, $urandom);
      if (!pend[0] && !pend[1]) new_req($urandom_range(0, 1), 1'($urandom), $urandom, $urandom);
      run_txn($urandom_range(0, MW + 3), $urandom);
    end

    // Reset during BUSY: outputs drop without a clock edge.
    new_req(0, 1'b0, 32'h200, 32'h0);
    new_req(1, 1'b0, 32'h300, 32'h0);
    drive_reqs();
    step();
    step();
    #2 reset = 1'b1;
    #1;
    chk("rst_busy_async", {mem_req, busy}, 0);
    step();
    reset = 1'b0;
    model_reset();
    new_req(0, 1'b0, 32'h200, 32'h0);
    run_txn(0, 32'h55556666);

    // Reset during DONE: ack drops at once; both still request afterwards.
    new_req(0, 1'b0, 32'h210, 32'h0);
    drive_reqs();
    g = (pend[0] && pend[1]) ? 1 - last_g : (pend[1] ? 1 : 0);
    step();
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    chk("pre_rst_ack", ack_of(g), 1);
    #2 reset = 1'b1;
    #1;
    chk("rst_done_async", {m0_ack, m1_ack, m0_err, m1_err, busy, mem_req}, 0);
    step();
    reset = 1'b0;
    model_reset();
    run_txn(0, 32'h77778888);
    run_txn(1, 32'h9999AAAA);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single unified instruction/data memory between two requesters: port 0 (the multicycle CPU core's fetch/load/store path) and port 1 (boot loader / debug DMA). It arbitrates round-robin, registers and holds one transaction toward the memory under a req/ready handshake, and returns a one-cycle ack with read data to the owner. A wait-state timeout aborts hung transactions with an error flag, so the CPU controller's FSM can never deadlock on memory.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MAX_WAIT, 15, max BUSY cycles without mem_ready before abort; 0 disables timeout

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- m0_req  in  1  port 0 request; held until m0_ack
- m0_we  in  1  port 0 write enable (1 write, 0 read)
- m0_addr  in  ADDR_W  port 0 address
- m0_wdata  in  DATA_W  port 0 write data
- m0_rdata  out  DATA_W  port 0 read data, valid with m0_ack on reads
- m0_ack  out  1  port 0 transaction complete, one cycle
- m0_err  out  1  port 0 timeout abort, coincident with m0_ack
- m1_req, m1_we, m1_addr, m1_wdata, m1_rdata, m1_ack, m1_err: same as port 0, for port 1
- mem_req  out  1  memory request, held until mem_ready or abort
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid with mem_ready
- mem_ready  in  1  memory completes current request
- owner  out  1  port owning the in-flight transaction
- busy  out  1  high in BUSY and DONE

## Operation
- States: IDLE, BUSY, DONE. Reset -> IDLE.
- IDLE: if no req, stay. If exactly one req, grant it. If both, grant the port opposite last_grant. On grant: latch owner, we, addr, wdata into mem_* registers; mem_req<=1; wait_cnt<=0; last_grant<=granted port; -> BUSY.
- BUSY: mem_* held stable. If mem_ready: mem_req<=0; owner's ack<=1; on read owner's rdata<=mem_rdata (write leaves rdata unchanged); -> DONE. Else if MAX_WAIT!=0 and wait_cnt==MAX_WAIT-1: mem_req<=0; ack<=1, err<=1, rdata unchanged; -> DONE. Else wait_cnt++.
- DONE: ack/err high this cycle only; all req inputs ignored (requester still holds req); next -> IDLE, ack/err<=0.
- Requester inputs are sampled only at grant; changes during BUSY have no effect.
- wait_cnt width: $clog2(MAX_WAIT+1), minimum 1; never wraps (abort occurs first).
- Non-owner port sees ack=0, err=0 and its rdata unchanged throughout.

## Timing
- All outputs registered. Reset values: mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, m0/m1_ack=0, m0/m1_err=0, m0/m1_rdata=0, owner=0, busy=0, last_grant=1 (port 0 wins first tie).
- Latency: req high at edge N in IDLE -> mem_req high from N+1. mem_ready sampled high at edge M -> ack high cycle M+1 (DONE) -> IDLE at M+2. Minimum (ready in first BUSY cycle): ack 2 cycles after req sample; back-to-back issue every 3 cycles.
- mem_ready and timeout at the same edge: ready wins, err=0, read data delivered.
- mem_ready while IDLE/DONE: ignored.
- Reset mid-transaction: asynchronous return to IDLE, mem_req and ack drop immediately, in-flight transaction lost, no err.
- Alternation under continuous contention: grants 0,1,0,1...

## Test plan
- Single read port 0: m0_req, addr 0x100, mem_ready one cycle after mem_req with rdata 0xDEADBEEF -> mem_addr=0x100, mem_we=0; m0_ack one cycle, m0_rdata=0xDEADBEEF, m0_err=0; m1_ack stays 0.
- Write port 1 with 3 wait states: addr 0x20, wdata 0x12345678 -> mem_req held 4 cycles with stable addr/wdata/we=1; m1_ack after ready; m1_rdata unchanged.
- Simultaneous requests from reset, both held continuously -> grant order 0,1,0,1 on owner; each ack once per 3+ cycles; no double ack.
- Timeout with MAX_WAIT=15, mem_ready never high -> mem_req drops after exactly 15 BUSY cycles; m0_ack=1 and m0_err=1 same cycle; next request proceeds normally.
- Ready on final wait cycle (cycle 15) -> normal completion, err=0, rdata captured.
- Reset asserted during BUSY -> mem_req, busy, ack go 0 asynchronously; after release, pending m0_req granted fresh with last_grant=1 tie-break.
